tilemap_write_ctrl: RTL
=======================

TILEMAP_WRITE_CTRL -- requirements
Module: tilemap_write_ctrl

Interface
REQ-001 The block SHALL have parameter ROWS, default 15, the number of tile-map rows.
REQ-002 The block SHALL have parameter COLS, default 20, the number of tile-map columns.
REQ-003 The block SHALL have parameter TILE_W, default 2, the width of a tile code in bits.
REQ-004 Clk  in  1  single system clock; all logic is on its rising edge.
REQ-005 Reset  in  1  reset, synchronous, active-high.
REQ-006 vblank  in  1  write window; tile-map writes are permitted only while it is 1.
REQ-007 req_valid  in  1  single-tile write request from game logic.
REQ-008 req_ready  out  1  combinational; the request is accepted in any cycle where req_valid=1 and req_ready=1.
REQ-009 req_row  in  4  target row.
REQ-010 req_col  in  5  target column.
REQ-011 req_tile  in  TILE_W  tile code to write.
REQ-012 fill_start  in  1  one-cycle pulse that starts a whole-map fill.
REQ-013 fill_tile  in  TILE_W  fill code, sampled on the fill_start cycle.
REQ-014 fill_busy  out  1  high while a fill is in progress.
REQ-015 map_we  out  1  registered write strobe to the tile-map storage.
REQ-016 map_row  out  4  registered write row.
REQ-017 map_col  out  5  registered write column.
REQ-018 map_data  out  TILE_W  registered write data.
REQ-019 fill_done  out  1  one-cycle pulse when a fill completes.
REQ-020 req_err  out  1  one-cycle pulse when an out-of-range request is dropped.

Function
REQ-021 FSM states SHALL be IDLE and FILL.
- IDLE->FILL on fill_start=1.
- FILL->IDLE in the cycle that issues the last write (row ROWS-1, col COLS-1).
REQ-022 req_ready SHALL be 1 only when state=IDLE, vblank=1 and fill_start=0; a simultaneous fill_start has priority over the request.
REQ-023 An accepted in-range request SHALL produce map_we=1 with its row, column and tile on the next cycle: latency 1, at most one write per cycle.
REQ-024 An accepted request with row>=ROWS or col>=COLS SHALL be consumed with no write, and req_err SHALL pulse on the next cycle.
REQ-025 Fill sequencing:
- Fill SHALL latch fill_tile and sweep row-major from (0,0) to (ROWS-1, COLS-1).
- It SHALL issue one write per cycle while vblank=1.
- col wraps COLS-1->0 with row+1.
REQ-026 While in FILL with vblank=0, the row/col counters SHALL hold, map_we SHALL be 0, and the sweep SHALL resume at the held address when vblank returns.
REQ-027 fill_start while in FILL SHALL be ignored: no restart and no change to the latched code.
REQ-028 fill_busy SHALL be 1 from the cycle after fill_start through the cycle of the last write.
REQ-029 fill_done SHALL pulse in the cycle after the last write is issued, which is the cycle the last map_we appears.
REQ-030 A full fill with vblank held at 1 SHALL take exactly ROWS*COLS cycles of map_we (300 by default).
REQ-031 map_row, map_col and map_data SHALL hold their previous values when map_we=0.
REQ-032 Counter arithmetic SHALL be unsigned and width-exact; no out-of-range address is ever driven with map_we=1.

Reset
REQ-033 On Reset=1 at a clock edge, the block SHALL set state=IDLE, the counters to 0, and map_we, map_row, map_col, map_data, fill_busy, fill_done and req_err to 0.
REQ-034 Reset SHALL abort a fill in progress: no map_we in the cycle after Reset, and no fill_done pulse.
REQ-035 req_ready SHALL be 0 while Reset=1.

Structure
REQ-036 A shared package tilemap_pkg SHALL hold:
- ROWS, COLS, TILE_W;
- the state enum;
- the row, column and tile typedefs.
The tile-map storage and the color mapper SHALL import this package.
REQ-037 The row/col wrap counter with hold-enable SHALL be a sub-module named tile_addr_counter; all else is in one module.

Verification
REQ-038 The bench SHALL cover these directed scenarios:
- vblank=1, request (3,7,2'b10) -> next cycle map_we=1, row=3, col=7, data=2'b10; req_err=0.
- vblank=0, req_valid=1 -> req_ready=0 and no write; raise vblank -> accepted and written 1 cycle later.
- Request (15,0) or (0,20) -> no map_we; req_err pulses once.
- fill_start with fill_tile=2'b01, vblank=1 -> 300 consecutive writes from (0,0) to (14,19), all data 01; fill_done once; fill_busy falls after the last write; req_ready=0 throughout.
- Fill with vblank dropped after write 45 for 10 cycles -> no writes during the gap; resumes at (2,5); still 300 writes total.
- Reset asserted at write 100 of a fill -> all outputs 0 next cycle, no fill_done, IDLE, request accepted afterwards.

Source files
------------

// File: rtl/tilemap_pkg.sv
// Shared tile-map types and default geometry for the write controller, storage and color mapper.
package tilemap_pkg;

  localparam int unsigned ROWS   = 15;
  localparam int unsigned COLS   = 20;
  localparam int unsigned TILE_W = 2;
  localparam int unsigned ROW_W  = 4;
  localparam int unsigned COL_W  = 5;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } state_e;

  typedef logic [ROW_W-1:0]  row_t;
  typedef logic [COL_W-1:0]  col_t;
  typedef logic [TILE_W-1:0] tile_t;

endpackage

// File: rtl/tile_addr_counter.sv
// Row-major tile address counter with clear and hold-enable; wraps to (0,0) after the last tile.
module tile_addr_counter
  import tilemap_pkg::*;
#(
  parameter int unsigned ROWS = tilemap_pkg::ROWS,
  parameter int unsigned COLS = tilemap_pkg::COLS
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output row_t row_q,
  output col_t col_q,
  output logic last_c
);

  localparam row_t ROW_LAST = row_t'(ROWS - 1);
  localparam col_t COL_LAST = col_t'(COLS - 1);

  row_t row_d;
  col_t col_d;

  assign last_c = (row_q == ROW_LAST) && (col_q == COL_LAST);

  // Column advances every enabled cycle; row advances on column wrap.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clr) begin
      row_d = '0;
      col_d = '0;
    end else if (en) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = last_c ? '0 : row_q + row_t'(1);
      end else begin
        col_d = col_q + col_t'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

endmodule

// File: rtl/tilemap_write_ctrl.sv
// Arbitrates single-tile writes and whole-map fills into tile-map storage, gated by vblank.
module tilemap_write_ctrl
  import tilemap_pkg::*;
#(
  parameter int unsigned ROWS   = tilemap_pkg::ROWS,
  parameter int unsigned COLS   = tilemap_pkg::COLS,
  parameter int unsigned TILE_W = tilemap_pkg::TILE_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vblank,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_row,
  input  logic [4:0]        req_col,
  input  logic [TILE_W-1:0] req_tile,
  input  logic              fill_start,
  input  logic [TILE_W-1:0] fill_tile,
  output logic              fill_busy,
  output logic              map_we,
  output logic [3:0]        map_row,
  output logic [4:0]        map_col,
  output logic [TILE_W-1:0] map_data,
  output logic              fill_done,
  output logic              req_err
);

  state_e              state_q, state_d;
  logic [TILE_W-1:0]   fill_tile_q, fill_tile_d;
  logic                map_we_q, map_we_d;
  row_t                map_row_q, map_row_d;
  col_t                map_col_q, map_col_d;
  logic [TILE_W-1:0]   map_data_q, map_data_d;
  logic                fill_busy_q, fill_busy_d;
  logic                fill_done_q, fill_done_d;
  logic                req_err_q, req_err_d;
  logic                req_ready_c;
  logic                req_in_range_c;
  logic                cnt_clr, cnt_en, cnt_last;
  row_t                cnt_row;
  col_t                cnt_col;

  tile_addr_counter #(
    .ROWS (ROWS),
    .COLS (COLS)
  ) u_addr (
    .clk    (clk),
    .reset  (reset),
    .clr    (cnt_clr),
    .en     (cnt_en),
    .row_q  (cnt_row),
    .col_q  (cnt_col),
    .last_c (cnt_last)
  );

  // A fill_start in the same cycle wins over a pending request.
  assign req_ready_c    = (state_q == ST_IDLE) && vblank && !fill_start && !reset;
  assign req_in_range_c = (32'(req_row) < ROWS) && (32'(req_col) < COLS);

  always_comb begin
    state_d     = state_q;
    fill_tile_d = fill_tile_q;
    map_we_d    = 1'b0;
    map_row_d   = map_row_q;
    map_col_d   = map_col_q;
    map_data_d  = map_data_q;
    fill_done_d = 1'b0;
    req_err_d   = 1'b0;
    cnt_clr     = 1'b0;
    cnt_en      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (fill_start) begin
          state_d     = ST_FILL;
          fill_tile_d = fill_tile;
          cnt_clr     = 1'b1;
        end else if (req_valid && req_ready_c) begin
          if (req_in_range_c) begin
            map_we_d   = 1'b1;
            map_row_d  = req_row;
            map_col_d  = req_col;
            map_data_d = req_tile;
          end else begin
            req_err_d = 1'b1;
          end
        end
      end
      ST_FILL: begin
        // Sweep pauses, holding its address, whenever vblank is low.
        if (vblank) begin
          map_we_d   = 1'b1;
          map_row_d  = cnt_row;
          map_col_d  = cnt_col;
          map_data_d = fill_tile_q;
          cnt_en     = 1'b1;
          if (cnt_last) begin
            state_d     = ST_IDLE;
            fill_done_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    fill_busy_d = (state_d == ST_FILL);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      fill_tile_q <= '0;
      map_we_q    <= 1'b0;
      map_row_q   <= '0;
      map_col_q   <= '0;
      map_data_q  <= '0;
      fill_busy_q <= 1'b0;
      fill_done_q <= 1'b0;
      req_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      fill_tile_q <= fill_tile_d;
      map_we_q    <= map_we_d;
      map_row_q   <= map_row_d;
      map_col_q   <= map_col_d;
      map_data_q  <= map_data_d;
      fill_busy_q <= fill_busy_d;
      fill_done_q <= fill_done_d;
      req_err_q   <= req_err_d;
    end
  end

  assign req_ready = req_ready_c;
  assign fill_busy = fill_busy_q;
  assign map_we    = map_we_q;
  assign map_row   = map_row_q;
  assign map_col   = map_col_q;
  assign map_data  = map_data_q;
  assign fill_done = fill_done_q;
  assign req_err   = req_err_q;

endmodule
